// File: rtl/pwm_pkg.sv
// pwm_capture shared definitions: register offsets, CTRL/STATUS bit
// indices and the capture state encoding.
package pwm_pkg;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_DIV    = 8'h04;
    localparam logic [7:0] ADDR_PERIOD = 8'h08;
    localparam logic [7:0] ADDR_HIGH   = 8'h0C;
    localparam logic [7:0] ADDR_STATUS = 8'h10;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int CTRL_INV     = 2;
    localparam int CTRL_ONESHOT = 3;

    localparam int ST_VALID   = 0;
    localparam int ST_OVERRUN = 1;
    localparam int ST_OVF     = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } cap_state_e;

endpackage

// File: rtl/pwm_capture_if.sv
// Simple register bus shared with the PWM generator. The master drives the
// strobes, address and write data; the slave returns combinational read data.
interface pwm_capture_if;
    logic        re_i;
    logic        we_i;
    logic [7:0]  addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  be_i;
    logic [31:0] rdata_o;

    modport master (output re_i, we_i, addr_i, wdata_i, be_i, input rdata_o);
    modport slave  (input re_i, we_i, addr_i, wdata_i, be_i, output rdata_o);
endinterface

// File: rtl/pwmcap_sync_edge.sv
// Input conditioning for pwm_capture: synchroniser, optional 3-sample
// majority filter (PWMCAP_GLITCH_FILTER_EN), polarity inversion and a
// single-flop edge detector producing one-cycle rise/fall pulses.
module pwmcap_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pin_i,
    input  logic inv_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   clean;
    logic                   lvl;
    logic                   lvl_q;

    // Metastability chain; the pin is fully asynchronous to clk_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= '0;
        else         sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
    end

    assign synced = sync_q[SYNC_STAGES-1];

`ifdef PWMCAP_GLITCH_FILTER_EN
    logic [1:0] hist_q;
    logic       filt_q;

    // Majority of the current and two previous samples, registered. A steady
    // change needs two agreeing samples plus the output flop, so both edges
    // are delayed by the same two cycles and single-cycle spikes never win.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hist_q <= '0;
            filt_q <= 1'b0;
        end else begin
            hist_q <= {hist_q[0], synced};
            filt_q <= (synced & hist_q[0]) | (synced & hist_q[1]) | (hist_q[0] & hist_q[1]);
        end
    end

    assign clean = filt_q;
`else
    assign clean = synced;
`endif

    assign lvl = clean ^ inv_i;

    // Previous level for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) lvl_q <= 1'b0;
        else         lvl_q <= lvl;
    end

    assign rise_o = lvl & ~lvl_q;
    assign fall_o = ~lvl & lvl_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM input capture: measures period and high time of i_pwm in prescaled
// clock ticks and exposes them on the register bus. Building with
// PWMCAP_GLITCH_FILTER_EN adds a majority filter in the input path.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CW          = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    pwm_capture_if.slave bus,
    input  logic         i_pwm,
    output logic         irq_o
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [3:0]    ctrl_q, ctrl_d;
    logic [CW-1:0] div_q, div_d;
    logic [2:0]    status_q, status_d;
    logic [CW-1:0] period_q, high_q;
    logic [CW-1:0] cnt_q, presc_q, fall_q;
    logic          irq_q;
    cap_state_e    state_q;

    logic wr, en, tick, cnt_sat, rise, fall;
    logic cap_ev, ovf_ev, oneshot_ev;
    logic unused_bits;

    assign wr          = bus.we_i & ~bus.re_i;
    assign en          = ctrl_q[CTRL_EN];
    // >= rather than == so a divisor lowered mid-count still ticks promptly
    // instead of waiting for the prescaler to wrap.
    assign tick        = (presc_q >= div_q);
    assign cnt_sat     = (cnt_q == CNT_MAX);
    assign unused_bits = ^{bus.be_i, bus.wdata_i[31:CW]};

    pwmcap_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .pin_i  (i_pwm),
        .inv_i  (ctrl_q[CTRL_INV]),
        .rise_o (rise),
        .fall_o (fall)
    );

    // Capture/overflow events seen by both the FSM and the status logic.
    always_comb begin
        cap_ev     = 1'b0;
        ovf_ev     = 1'b0;
        oneshot_ev = 1'b0;
        if (en && state_q == MEAS) begin
            if (rise && !cnt_sat) begin
                cap_ev     = 1'b1;
                oneshot_ev = ctrl_q[CTRL_ONESHOT];
            end
            if (cnt_sat) ovf_ev = 1'b1;
        end
    end

    // Measurement FSM with its counters and the captured results.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            presc_q  <= '0;
            fall_q   <= '0;
            period_q <= '0;
            high_q   <= '0;
        end else if (!en) begin
            // Disabled (including the cycle after software clears EN):
            // any edge now is ignored, results are retained.
            state_q <= IDLE;
            cnt_q   <= '0;
            presc_q <= '0;
            fall_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= ARM;
                    cnt_q   <= '0;
                    presc_q <= '0;
                    fall_q  <= '0;
                end
                ARM: begin
                    // First rising edge only marks the start of a period.
                    if (rise) begin
                        cnt_q   <= {{(CW-1){1'b0}}, 1'b1};
                        presc_q <= '0;
                        fall_q  <= '0;
                        state_q <= MEAS;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        if (cap_ev) begin
                            period_q <= cnt_q;
                            high_q   <= fall_q;
                        end
                        cnt_q   <= {{(CW-1){1'b0}}, 1'b1};
                        presc_q <= '0;
                        fall_q  <= '0;
                        if (oneshot_ev) state_q <= IDLE;
                    end else if (cnt_sat) begin
                        // Period too long or input stuck: rearm without capture.
                        state_q <= ARM;
                        cnt_q   <= '0;
                        presc_q <= '0;
                        fall_q  <= '0;
                    end else begin
                        if (fall) fall_q <= cnt_q;
                        if (tick) begin
                            cnt_q   <= cnt_q + 1'b1;
                            presc_q <= '0;
                        end else begin
                            presc_q <= presc_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Next-state for software registers; hardware sets win over W1C, while a
    // software CTRL write wins over the one-shot EN clear.
    always_comb begin
        ctrl_d   = ctrl_q;
        div_d    = div_q;
        status_d = status_q;
        if (oneshot_ev) ctrl_d[CTRL_EN] = 1'b0;
        if (wr) begin
            case (bus.addr_i)
                ADDR_CTRL:   ctrl_d   = bus.wdata_i[3:0];
                ADDR_DIV:    div_d    = bus.wdata_i[CW-1:0];
                ADDR_STATUS: status_d = status_q & ~bus.wdata_i[2:0];
                default: ;
            endcase
        end
        if (cap_ev) begin
            status_d[ST_VALID] = 1'b1;
            if (status_q[ST_VALID]) status_d[ST_OVERRUN] = 1'b1;
        end
        if (ovf_ev) status_d[ST_OVF] = 1'b1;
    end

    // Software-visible registers and the level interrupt.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_q   <= '0;
            div_q    <= '0;
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            div_q    <= div_d;
            status_q <= status_d;
            irq_q    <= status_q[ST_VALID] & ctrl_q[CTRL_IRQ_EN];
        end
    end

    assign irq_o = irq_q;

    // Combinational read mux, zero-extended; unmapped offsets read 0.
    always_comb begin
        bus.rdata_o = '0;
        case (bus.addr_i)
            ADDR_CTRL:   bus.rdata_o = {28'd0, ctrl_q};
            ADDR_DIV:    bus.rdata_o = 32'(div_q);
            ADDR_PERIOD: bus.rdata_o = 32'(period_q);
            ADDR_HIGH:   bus.rdata_o = 32'(high_q);
            ADDR_STATUS: bus.rdata_o = {29'd0, status_q};
            default:     bus.rdata_o = '0;
        endcase
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: register access, capture at DIV=0/3,
// overrun and irq, overflow rearm, one-shot, optional glitch filter and
// asynchronous reset.
module tb_pwm_capture;
    import pwm_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic pwm   = 1'b0;
    logic irq;
    int   n_cmp = 0;
    int   n_err = 0;

    pwm_capture_if bus ();

    pwm_capture #(.CW(16), .SYNC_STAGES(2)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus),
        .i_pwm  (pwm),
        .irq_o  (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.we_i = 1'b1; bus.addr_i = a; bus.wdata_i = d;
        @(negedge clk);
        bus.we_i = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        bus.addr_i = a; bus.re_i = 1'b1;
        #1;
        check(tag, bus.rdata_o, exp);
        bus.re_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulses(input int h, input int l, input int n);
        repeat (n) begin
            pwm = 1'b1; idle(h);
            pwm = 1'b0; idle(l);
        end
    endtask

    task automatic rise_settle();
        pwm = 1'b1; idle(10);
    endtask

    initial begin
        bus.re_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0;
        bus.wdata_i = '0; bus.be_i = 4'hF;

        // Reset state
        idle(3);
        rd_chk("rst_ctrl", ADDR_CTRL, 0);
        rd_chk("rst_period", ADDR_PERIOD, 0);
        rd_chk("rst_status", ADDR_STATUS, 0);
        check("rst_irq", irq, 0);
        rst_n = 1'b1;
        idle(2);

        // DIV=0, 10 high / 30 low
        wr(ADDR_DIV, 0);
        wr(ADDR_CTRL, 1);
        idle(5);
        pulses(10, 30, 1);
        rise_settle();
        rd_chk("t1_period", ADDR_PERIOD, 40);
        rd_chk("t1_high", ADDR_HIGH, 10);
        rd_chk("t1_status", ADDR_STATUS, 1);
        rd_chk("t1_ctrl", ADDR_CTRL, 1);
        check("t1_irq_off", irq, 0);
        wr(ADDR_PERIOD, 32'hFFFF);
        rd_chk("ro_period", ADDR_PERIOD, 40);
        rd_chk("unmapped", 8'h14, 0);

        // DIV=3, 12 high / 28 low
        wr(ADDR_DIV, 3);
        rd_chk("t2_div", ADDR_DIV, 3);
        wr(ADDR_STATUS, 7);
        pwm = 1'b0; idle(20);
        pulses(12, 28, 2);
        rise_settle();
        rd_chk("t2_period", ADDR_PERIOD, 10);
        rd_chk("t2_high", ADDR_HIGH, 3);
        rd_chk("t2_status", ADDR_STATUS, 3);

        // Overrun and interrupt
        wr(ADDR_STATUS, 7);
        wr(ADDR_CTRL, 3);
        idle(2);
        rd_chk("t3_status_clr", ADDR_STATUS, 0);
        check("t3_irq_low", irq, 0);
        pwm = 1'b0; idle(20);
        pulses(12, 28, 2);
        rise_settle();
        rd_chk("t3_status_ovr", ADDR_STATUS, 3);
        check("t3_irq_high", irq, 1);
        wr(ADDR_STATUS, 3);
        rd_chk("t3_status_w1c", ADDR_STATUS, 0);
        check("t3_irq_lag", irq, 1);
        idle(1);
        check("t3_irq_clr", irq, 0);

        // Overflow on a stuck-high input
        wr(ADDR_CTRL, 1);
        wr(ADDR_DIV, 0);
        pwm = 1'b0; idle(20);
        pulses(10, 30, 1);
        rise_settle();
        wr(ADDR_STATUS, 7);
        rd_chk("t4_period", ADDR_PERIOD, 40);
        rd_chk("t4_status0", ADDR_STATUS, 0);
        idle(64900);
        rd_chk("t4_no_ovf_yet", ADDR_STATUS, 0);
        idle(700);
        rd_chk("t4_ovf", ADDR_STATUS, 4);
        rd_chk("t4_period_kept", ADDR_PERIOD, 40);
        pwm = 1'b0; idle(30);
        pulses(12, 28, 1);
        rd_chk("t4_armed_no_cap", ADDR_STATUS, 4);
        rise_settle();
        rd_chk("t4_recap_period", ADDR_PERIOD, 40);
        rd_chk("t4_recap_high", ADDR_HIGH, 12);
        rd_chk("t4_recap_status", ADDR_STATUS, 5);

        // One-shot
        wr(ADDR_CTRL, 0);
        wr(ADDR_STATUS, 7);
        wr(ADDR_CTRL, 9);
        pwm = 1'b0; idle(20);
        pulses(15, 25, 1);
        rise_settle();
        rd_chk("t5_ctrl", ADDR_CTRL, 8);
        rd_chk("t5_period", ADDR_PERIOD, 40);
        rd_chk("t5_high", ADDR_HIGH, 15);
        rd_chk("t5_status", ADDR_STATUS, 1);
        pwm = 1'b0; idle(10);
        pulses(5, 5, 3);
        rise_settle();
        rd_chk("t5_period_hold", ADDR_PERIOD, 40);
        rd_chk("t5_high_hold", ADDR_HIGH, 15);
        rd_chk("t5_ctrl_hold", ADDR_CTRL, 8);

`ifdef PWMCAP_GLITCH_FILTER_EN
        // Single-clock spikes in the low phase are rejected
        wr(ADDR_CTRL, 1);
        wr(ADDR_STATUS, 7);
        pwm = 1'b0; idle(20);
        repeat (2) begin
            pwm = 1'b1; idle(10);
            pwm = 1'b0; idle(10);
            pwm = 1'b1; idle(1);
            pwm = 1'b0; idle(19);
        end
        rise_settle();
        rd_chk("t6_period", ADDR_PERIOD, 40);
        rd_chk("t6_high", ADDR_HIGH, 10);
`endif

        // Asynchronous reset mid-period
        wr(ADDR_CTRL, 3);
        wr(ADDR_DIV, 5);
        pwm = 1'b0; idle(10);
        pwm = 1'b1; idle(7);
        #2 rst_n = 1'b0;
        idle(1);
        rd_chk("t7_ctrl", ADDR_CTRL, 0);
        rd_chk("t7_div", ADDR_DIV, 0);
        rd_chk("t7_period", ADDR_PERIOD, 0);
        rd_chk("t7_high", ADDR_HIGH, 0);
        rd_chk("t7_status", ADDR_STATUS, 0);
        check("t7_irq", irq, 0);
        rst_n = 1'b1;
        pwm = 1'b0; idle(5);
        pwm = 1'b1; idle(5);
        rd_chk("t7_period_post", ADDR_PERIOD, 0);
        rd_chk("t7_status_post", ADDR_STATUS, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
